// File: rtl/bsv_pkg.sv
// Shared definitions for the XDMA loopback user block: register offsets,
// FSM states, the descriptor bundle driven onto both bypass ports, and the
// byte-enable merge used by the host-writable registers.
package bsv_pkg;

  localparam logic [7:0] REG_SRC_LO = 8'h00;
  localparam logic [7:0] REG_SRC_HI = 8'h04;
  localparam logic [7:0] REG_DST_LO = 8'h08;
  localparam logic [7:0] REG_DST_HI = 8'h0C;
  localparam logic [7:0] REG_LEN    = 8'h10;
  localparam logic [7:0] REG_CTRL   = 8'h14;
  localparam logic [7:0] REG_STATUS = 8'h18;
  localparam logic [7:0] REG_BEATS  = 8'h1C;
  localparam logic [7:0] REG_ID     = 8'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [27:0] len;
    logic [15:0] ctl;
  } desc_t;

  localparam desc_t       DESC_RST  = '0;
  localparam logic [63:0] ADDR_RST  = '0;
  localparam logic [27:0] LEN_RST   = '0;
  localparam logic [31:0] WORD_RST  = '0;

  // Byte-wise merge of a write into an existing 32-bit register.
  function automatic logic [31:0] apply_strb(logic [31:0] old_v, logic [31:0] new_v,
                                             logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/bsv_top_axis_loop_fifo.sv
// axis_loop_fifo: 2-entry stream FIFO carrying {tdata,tkeep,tlast} from the
// H2C stream to the C2H stream.
//   in_*  : upstream AXI-Stream slave (in_tready = !full)
//   out_* : downstream AXI-Stream master, driven from the head entry
module axis_loop_fifo #(
  parameter int DATA_W = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_tvalid,
  input  logic [DATA_W-1:0]   in_tdata,
  input  logic [DATA_W/8-1:0] in_tkeep,
  input  logic                in_tlast,
  output logic                in_tready,
  output logic                out_tvalid,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [DATA_W/8-1:0] out_tkeep,
  output logic                out_tlast,
  input  logic                out_tready
);
  localparam int ENT_W = DATA_W + DATA_W/8 + 1;

  logic [1:0][ENT_W-1:0] mem_q, mem_d;
  logic                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop;

  assign in_tready  = (cnt_q != 2'd2);
  assign out_tvalid = (cnt_q != 2'd0);
  assign push       = in_tvalid & in_tready;
  assign pop        = out_tvalid & out_tready;
  assign {out_tdata, out_tkeep, out_tlast} = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = {in_tdata, in_tkeep, in_tlast};
      wptr_d        = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
    // push and pop in the same cycle leave the occupancy unchanged
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bsv_top.sv
// bsv_top: XDMA user-logic top. AXI4-Lite register block (SRC/DST/LEN/CTRL/
// STATUS/BEATS/ID), a one-shot descriptor FSM issuing one H2C and one C2H
// bypass descriptor per start, and an H2C->C2H loopback through a 2-entry FIFO.
//   CLK/RST_N                 : user clock, async active-low reset
//   xdmaChannel_raw*AxiStream : H2C in / C2H out streams
//   xdmaChannel_*DescByp      : descriptor bypass ports
//   axilRegBlock_*            : AXI4-Lite slave
module bsv_top
  import bsv_pkg::*;
#(
  parameter int          DATA_W   = 256,
  parameter logic [15:0] DESC_CTL = 16'h0001,
  parameter logic [31:0] BLOCK_ID = 32'h5244_4D41
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                xdmaChannel_rawH2cAxiStream_tvalid,
  input  logic [DATA_W-1:0]   xdmaChannel_rawH2cAxiStream_tdata,
  input  logic [DATA_W/8-1:0] xdmaChannel_rawH2cAxiStream_tkeep,
  input  logic                xdmaChannel_rawH2cAxiStream_tlast,
  output logic                xdmaChannel_rawH2cAxiStream_tready,
  output logic                xdmaChannel_rawC2hAxiStream_tvalid,
  output logic [DATA_W-1:0]   xdmaChannel_rawC2hAxiStream_tdata,
  output logic [DATA_W/8-1:0] xdmaChannel_rawC2hAxiStream_tkeep,
  output logic                xdmaChannel_rawC2hAxiStream_tlast,
  input  logic                xdmaChannel_rawC2hAxiStream_tready,
  input  logic                xdmaChannel_h2cDescByp_ready,
  output logic                xdmaChannel_h2cDescByp_load,
  output logic [63:0]         xdmaChannel_h2cDescByp_src_addr,
  output logic [63:0]         xdmaChannel_h2cDescByp_dst_addr,
  output logic [27:0]         xdmaChannel_h2cDescByp_len,
  output logic [15:0]         xdmaChannel_h2cDescByp_ctl,
  input  logic                xdmaChannel_h2cDescByp_desc_done,
  input  logic                xdmaChannel_c2hDescByp_ready,
  output logic                xdmaChannel_c2hDescByp_load,
  output logic [63:0]         xdmaChannel_c2hDescByp_src_addr,
  output logic [63:0]         xdmaChannel_c2hDescByp_dst_addr,
  output logic [27:0]         xdmaChannel_c2hDescByp_len,
  output logic [15:0]         xdmaChannel_c2hDescByp_ctl,
  input  logic                xdmaChannel_c2hDescByp_desc_done,
  input  logic                axilRegBlock_awvalid,
  input  logic [31:0]         axilRegBlock_awaddr,
  input  logic [2:0]          axilRegBlock_awprot,
  output logic                axilRegBlock_awready,
  input  logic                axilRegBlock_wvalid,
  input  logic [31:0]         axilRegBlock_wdata,
  input  logic [3:0]          axilRegBlock_wstrb,
  output logic                axilRegBlock_wready,
  output logic                axilRegBlock_bvalid,
  output logic [1:0]          axilRegBlock_bresp,
  input  logic                axilRegBlock_bready,
  input  logic                axilRegBlock_arvalid,
  input  logic [31:0]         axilRegBlock_araddr,
  input  logic [2:0]          axilRegBlock_arprot,
  output logic                axilRegBlock_arready,
  output logic                axilRegBlock_rvalid,
  output logic [1:0]          axilRegBlock_rresp,
  output logic [31:0]         axilRegBlock_rdata,
  input  logic                axilRegBlock_rready
);

  logic [63:0] src_q, src_d, dst_q, dst_d;
  logic [27:0] len_q, len_d;
  logic [31:0] beats_q, beats_d, rdata_q, rdata_d, rd_val, len_wr;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic        wr_en, ar_hs, start, c2h_hs;
  state_e      state_q;
  desc_t       h2c_desc_q, c2h_desc_q;
  logic        h2c_load_q, c2h_load_q, h2c_seen_q, c2h_seen_q;
  logic        unused_ok;

  assign unused_ok = ^{axilRegBlock_awprot, axilRegBlock_arprot, axilRegBlock_awaddr[31:8],
                       axilRegBlock_araddr[31:8], len_wr[31:28]};

  // ---------------- AXI-Lite register block ----------------
  assign wr_en                = axilRegBlock_awvalid & axilRegBlock_wvalid & ~bvalid_q;
  assign axilRegBlock_awready = wr_en;
  assign axilRegBlock_wready  = wr_en;
  assign axilRegBlock_bvalid  = bvalid_q;
  assign axilRegBlock_bresp   = 2'b00;
  assign ar_hs                = axilRegBlock_arvalid & ~rvalid_q;
  assign axilRegBlock_arready = ~rvalid_q;
  assign axilRegBlock_rvalid  = rvalid_q;
  assign axilRegBlock_rresp   = 2'b00;
  assign axilRegBlock_rdata   = rdata_q;

  assign start  = wr_en && (axilRegBlock_awaddr[7:0] == REG_CTRL) && axilRegBlock_wdata[0];
  assign len_wr = apply_strb({4'h0, len_q}, axilRegBlock_wdata, axilRegBlock_wstrb);
  assign c2h_hs = xdmaChannel_rawC2hAxiStream_tvalid & xdmaChannel_rawC2hAxiStream_tready;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    if (wr_en) begin
      case (axilRegBlock_awaddr[7:0])
        REG_SRC_LO: src_d[31:0]  = apply_strb(src_q[31:0],  axilRegBlock_wdata, axilRegBlock_wstrb);
        REG_SRC_HI: src_d[63:32] = apply_strb(src_q[63:32], axilRegBlock_wdata, axilRegBlock_wstrb);
        REG_DST_LO: dst_d[31:0]  = apply_strb(dst_q[31:0],  axilRegBlock_wdata, axilRegBlock_wstrb);
        REG_DST_HI: dst_d[63:32] = apply_strb(dst_q[63:32], axilRegBlock_wdata, axilRegBlock_wstrb);
        REG_LEN:    len_d        = len_wr[27:0];
        default: ;
      endcase
    end
    // A start accepted from IDLE restarts the beat count; it wins over a same-cycle beat.
    beats_d = beats_q;
    if (start && state_q == ST_IDLE) beats_d = '0;
    else if (c2h_hs)                 beats_d = beats_q + 32'd1;

    rd_val = '0;
    case (axilRegBlock_araddr[7:0])
      REG_SRC_LO: rd_val = src_q[31:0];
      REG_SRC_HI: rd_val = src_q[63:32];
      REG_DST_LO: rd_val = dst_q[31:0];
      REG_DST_HI: rd_val = dst_q[63:32];
      REG_LEN:    rd_val = {4'h0, len_q};
      REG_STATUS: rd_val = {29'h0, c2h_seen_q, h2c_seen_q, state_q != ST_IDLE};
      REG_BEATS:  rd_val = beats_q;
      REG_ID:     rd_val = BLOCK_ID;
      default:    rd_val = '0;
    endcase
    rdata_d  = ar_hs ? rd_val : rdata_q;
    rvalid_d = ar_hs ? 1'b1 : (axilRegBlock_rready ? 1'b0 : rvalid_q);
    bvalid_d = wr_en ? 1'b1 : (axilRegBlock_bready ? 1'b0 : bvalid_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      src_q    <= ADDR_RST;
      dst_q    <= ADDR_RST;
      len_q    <= LEN_RST;
      beats_q  <= WORD_RST;
      rdata_q  <= WORD_RST;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      beats_q  <= beats_d;
      rdata_q  <= rdata_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
    end
  end

  // ---------------- descriptor FSM ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      h2c_desc_q <= DESC_RST;
      c2h_desc_q <= DESC_RST;
      h2c_load_q <= 1'b0;
      c2h_load_q <= 1'b0;
      h2c_seen_q <= 1'b0;
      c2h_seen_q <= 1'b0;
    end else begin
      // Completions are tracked in every non-idle state so an early done during ISSUE is kept.
      if (state_q != ST_IDLE) begin
        if (xdmaChannel_h2cDescByp_desc_done) h2c_seen_q <= 1'b1;
        if (xdmaChannel_c2hDescByp_desc_done) c2h_seen_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: if (start) begin
          state_q    <= ST_ISSUE;
          h2c_desc_q <= '{src: src_q, dst: 64'h0, len: len_q, ctl: DESC_CTL};
          c2h_desc_q <= '{src: 64'h0, dst: dst_q, len: len_q, ctl: DESC_CTL};
          h2c_load_q <= 1'b1;
          c2h_load_q <= 1'b1;
          h2c_seen_q <= 1'b0;
          c2h_seen_q <= 1'b0;
        end
        ST_ISSUE: begin
          if (h2c_load_q && xdmaChannel_h2cDescByp_ready) h2c_load_q <= 1'b0;
          if (c2h_load_q && xdmaChannel_c2hDescByp_ready) c2h_load_q <= 1'b0;
          // Done with issue once each side has handshaken, earlier or in this cycle.
          if ((!h2c_load_q || xdmaChannel_h2cDescByp_ready) &&
              (!c2h_load_q || xdmaChannel_c2hDescByp_ready)) state_q <= ST_WAIT;
        end
        ST_WAIT: if (h2c_seen_q && c2h_seen_q) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign xdmaChannel_h2cDescByp_load     = h2c_load_q;
  assign xdmaChannel_h2cDescByp_src_addr = h2c_desc_q.src;
  assign xdmaChannel_h2cDescByp_dst_addr = h2c_desc_q.dst;
  assign xdmaChannel_h2cDescByp_len      = h2c_desc_q.len;
  assign xdmaChannel_h2cDescByp_ctl      = h2c_desc_q.ctl;
  assign xdmaChannel_c2hDescByp_load     = c2h_load_q;
  assign xdmaChannel_c2hDescByp_src_addr = c2h_desc_q.src;
  assign xdmaChannel_c2hDescByp_dst_addr = c2h_desc_q.dst;
  assign xdmaChannel_c2hDescByp_len      = c2h_desc_q.len;
  assign xdmaChannel_c2hDescByp_ctl      = c2h_desc_q.ctl;

  // ---------------- loopback ----------------
  axis_loop_fifo #(.DATA_W(DATA_W)) u_loop (
    .clk        (CLK),
    .rst_n      (RST_N),
    .in_tvalid  (xdmaChannel_rawH2cAxiStream_tvalid),
    .in_tdata   (xdmaChannel_rawH2cAxiStream_tdata),
    .in_tkeep   (xdmaChannel_rawH2cAxiStream_tkeep),
    .in_tlast   (xdmaChannel_rawH2cAxiStream_tlast),
    .in_tready  (xdmaChannel_rawH2cAxiStream_tready),
    .out_tvalid (xdmaChannel_rawC2hAxiStream_tvalid),
    .out_tdata  (xdmaChannel_rawC2hAxiStream_tdata),
    .out_tkeep  (xdmaChannel_rawC2hAxiStream_tkeep),
    .out_tlast  (xdmaChannel_rawC2hAxiStream_tlast),
    .out_tready (xdmaChannel_rawC2hAxiStream_tready)
  );

endmodule

// File: tb/tb_bsv_top.sv
// Scoreboard bench for bsv_top: read data and loopback beats are queued when
// stimulus is driven and compared when the DUT presents them.
module tb_bsv_top;
  localparam int DW = 256;
  localparam int KW = DW/8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk, rst_n;
  logic          h2c_tvalid, h2c_tlast, h2c_tready;
  logic [DW-1:0] h2c_tdata;
  logic [KW-1:0] h2c_tkeep;
  logic          c2h_tvalid, c2h_tlast, c2h_tready;
  logic [DW-1:0] c2h_tdata;
  logic [KW-1:0] c2h_tkeep;
  logic          h2c_rdy, h2c_load, h2c_done, c2h_rdy, c2h_load, c2h_done;
  logic [63:0]   h2c_src, h2c_dst, c2h_src, c2h_dst;
  logic [27:0]   h2c_len, c2h_len;
  logic [15:0]   h2c_ctl, c2h_ctl;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   awaddr, araddr, wdata, rdata;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int            n_chk, n_pass;
  int            h2c_hs_n, c2h_hs_n;
  logic [63:0]   c2h_cap_src, c2h_cap_dst;
  logic [27:0]   c2h_cap_len;
  logic [15:0]   c2h_cap_ctl;
  logic [31:0]   rd_q[$];
  beat_t         beat_q[$];

  bsv_top dut (
    .CLK(clk), .RST_N(rst_n),
    .xdmaChannel_rawH2cAxiStream_tvalid(h2c_tvalid), .xdmaChannel_rawH2cAxiStream_tdata(h2c_tdata),
    .xdmaChannel_rawH2cAxiStream_tkeep(h2c_tkeep), .xdmaChannel_rawH2cAxiStream_tlast(h2c_tlast),
    .xdmaChannel_rawH2cAxiStream_tready(h2c_tready),
    .xdmaChannel_rawC2hAxiStream_tvalid(c2h_tvalid), .xdmaChannel_rawC2hAxiStream_tdata(c2h_tdata),
    .xdmaChannel_rawC2hAxiStream_tkeep(c2h_tkeep), .xdmaChannel_rawC2hAxiStream_tlast(c2h_tlast),
    .xdmaChannel_rawC2hAxiStream_tready(c2h_tready),
    .xdmaChannel_h2cDescByp_ready(h2c_rdy), .xdmaChannel_h2cDescByp_load(h2c_load),
    .xdmaChannel_h2cDescByp_src_addr(h2c_src), .xdmaChannel_h2cDescByp_dst_addr(h2c_dst),
    .xdmaChannel_h2cDescByp_len(h2c_len), .xdmaChannel_h2cDescByp_ctl(h2c_ctl),
    .xdmaChannel_h2cDescByp_desc_done(h2c_done),
    .xdmaChannel_c2hDescByp_ready(c2h_rdy), .xdmaChannel_c2hDescByp_load(c2h_load),
    .xdmaChannel_c2hDescByp_src_addr(c2h_src), .xdmaChannel_c2hDescByp_dst_addr(c2h_dst),
    .xdmaChannel_c2hDescByp_len(c2h_len), .xdmaChannel_c2hDescByp_ctl(c2h_ctl),
    .xdmaChannel_c2hDescByp_desc_done(c2h_done),
    .axilRegBlock_awvalid(awvalid), .axilRegBlock_awaddr(awaddr), .axilRegBlock_awprot(awprot),
    .axilRegBlock_awready(awready),
    .axilRegBlock_wvalid(wvalid), .axilRegBlock_wdata(wdata), .axilRegBlock_wstrb(wstrb),
    .axilRegBlock_wready(wready),
    .axilRegBlock_bvalid(bvalid), .axilRegBlock_bresp(bresp), .axilRegBlock_bready(bready),
    .axilRegBlock_arvalid(arvalid), .axilRegBlock_araddr(araddr), .axilRegBlock_arprot(arprot),
    .axilRegBlock_arready(arready),
    .axilRegBlock_rvalid(rvalid), .axilRegBlock_rresp(rresp), .axilRegBlock_rdata(rdata),
    .axilRegBlock_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // descriptor handshake monitor
  always @(posedge clk) begin
    if (h2c_load && h2c_rdy) h2c_hs_n++;
    if (c2h_load && c2h_rdy) begin
      c2h_hs_n++;
      c2h_cap_src = c2h_src; c2h_cap_dst = c2h_dst;
      c2h_cap_len = c2h_len; c2h_cap_ctl = c2h_ctl;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic axil_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold);
    bit ok = 0;
    @(negedge clk);
    awvalid = 1; wvalid = 1; awaddr = {24'h0, a}; wdata = d; wstrb = s;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (awready && wready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("aw_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
    end
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axil_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bit ok = 0;
    logic [31:0] e;
    rd_q.push_back(exp);
    @(negedge clk);
    arvalid = 1; araddr = {24'h0, a};
    #1 chk("arready", arready, 1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin ok = 1; break; end
      @(negedge clk);
    end
    e = rd_q.pop_front();
    if (!ok) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk(tag, rdata, e);
      chk("rresp", rresp, 0);
      rready = 1;
      @(posedge clk);
      @(negedge clk);
      rready = 0;
    end
  endtask

  task automatic pulse(input bit is_h2c);
    @(negedge clk);
    if (is_h2c) h2c_done = 1; else c2h_done = 1;
    @(negedge clk);
    h2c_done = 0; c2h_done = 0;
  endtask

  // Pop n beats from the C2H side (random tready when rnd) and compare with the scoreboard.
  task automatic drain(input int n, input bit rnd);
    int got = 0;
    beat_t b;
    for (int i = 0; i < 400 && got < n; i++) begin
      @(negedge clk);
      c2h_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (c2h_tvalid && c2h_tready) begin
        if (beat_q.size() == 0) chk("c2h_unexpected", 1, 0);
        else begin
          b = beat_q.pop_front();
          chk("c2h_tdata", c2h_tdata, b.data);
          chk("c2h_tkeep_tlast", {c2h_tkeep, c2h_tlast}, {b.keep, b.last});
        end
        got++;
      end
    end
    if (got < n) chk("drain_timeout", got, n);
    @(negedge clk);
    c2h_tready = 0;
  endtask

  task automatic produce(input int n, input bit rnd);
    int sent = 0;
    beat_t b;
    for (int i = 0; i < 400 && sent < n; i++) begin
      @(negedge clk);
      h2c_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      b.data = {8{$urandom()}};
      b.keep = $urandom();
      b.last = (sent == n - 1);
      h2c_tdata = b.data; h2c_tkeep = b.keep; h2c_tlast = b.last;
      #1;
      if (h2c_tvalid && h2c_tready) begin
        beat_q.push_back(b);
        sent++;
      end
    end
    if (sent < n) chk("produce_timeout", sent, n);
    @(negedge clk);
    h2c_tvalid = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; h2c_hs_n = 0; c2h_hs_n = 0;
    rst_n = 0;
    h2c_tvalid = 0; h2c_tdata = '0; h2c_tkeep = '0; h2c_tlast = 0; c2h_tready = 0;
    h2c_rdy = 0; c2h_rdy = 0; h2c_done = 0; c2h_done = 0;
    awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; arprot = 0; rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_loads", {h2c_load, c2h_load}, 0);
    chk("rst_ctl", {h2c_ctl, c2h_ctl}, 0);
    chk("rst_c2h_tvalid", c2h_tvalid, 0);
    chk("rst_bv_rv", {bvalid, rvalid}, 0);
    rst_n = 1;

    axil_rd("id", 8'h20, 32'h5244_4D41);
    axil_rd("status_rst", 8'h18, 0);
    axil_rd("beats_rst", 8'h1C, 0);
    axil_rd("unmapped", 8'h40, 0);

    // descriptor issue, h2c ready held low
    c2h_rdy = 1;
    axil_wr(8'h00, 32'h0000_1000, 4'hF, 0);
    axil_wr(8'h04, 32'h0000_0001, 4'hF, 0);
    axil_wr(8'h08, 32'h0000_2000, 4'hF, 0);
    axil_wr(8'h0C, 32'h0000_0002, 4'hF, 0);
    axil_wr(8'h10, 32'd64, 4'hF, 0);
    axil_wr(8'h40, 32'hDEAD_BEEF, 4'hF, 0);
    axil_rd("src_hi", 8'h04, 1);
    axil_rd("len", 8'h10, 64);
    axil_rd("ctrl_reads0", 8'h14, 0);
    axil_wr(8'h14, 32'h1, 4'hF, 0);
    chk("h2c_load_held", h2c_load, 1);
    chk("c2h_load_dropped", c2h_load, 0);
    chk("c2h_hs_once", c2h_hs_n, 1);
    chk("c2h_desc_src", c2h_cap_src, 0);
    chk("c2h_desc_dst", c2h_cap_dst, 64'h2_0000_2000);
    chk("c2h_desc_len_ctl", {c2h_cap_len, c2h_cap_ctl}, {28'd64, 16'h0001});
    chk("h2c_desc_src", h2c_src, 64'h1_0000_1000);
    chk("h2c_desc_dst", h2c_dst, 0);
    chk("h2c_desc_len_ctl", {h2c_len, h2c_ctl}, {28'd64, 16'h0001});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("h2c_load_wait", h2c_load, 1);
    end
    axil_rd("status_issue", 8'h18, 32'h1);
    @(negedge clk);
    h2c_rdy = 1;
    @(negedge clk);
    chk("h2c_load_drop", h2c_load, 0);
    chk("h2c_hs_once", h2c_hs_n, 1);

    // WAIT: restart ignored, done pulses collected
    axil_wr(8'h14, 32'h1, 4'hF, 0);
    chk("wait_start_ignored", {h2c_load, c2h_load}, 0);
    chk("hs_counts", {h2c_hs_n[7:0], c2h_hs_n[7:0]}, {8'd1, 8'd1});
    pulse(0);
    axil_rd("status_c2h_done", 8'h18, 32'h5);
    pulse(1);
    repeat (2) @(negedge clk);
    axil_rd("status_both_done", 8'h18, 32'h6);

    // loopback: fill with C2H stalled, then drain
    produce(2, 0);
    #1 chk("h2c_tready_full", h2c_tready, 0);
    drain(2, 0);
    axil_rd("beats_2", 8'h1C, 2);

    // concurrent push/pop with random backpressure on both sides
    fork
      produce(6, 1);
      drain(6, 1);
    join
    chk("sb_empty", beat_q.size(), 0);
    axil_rd("beats_8", 8'h1C, 8);

    // byte strobes
    axil_wr(8'h00, 32'hFFFF_FFFF, 4'hF, 0);
    axil_wr(8'h00, 32'h1234_5678, 4'b0011, 3);
    axil_rd("src_lo_strb", 8'h00, 32'hFFFF_5678);
    axil_wr(8'h10, 32'hFFFF_FFFF, 4'hF, 0);
    axil_rd("len_mask", 8'h10, 32'h0FFF_FFFF);

    // mid-operation reset drops buffered data
    produce(1, 0);
    @(negedge clk);
    chk("beat_buffered", c2h_tvalid, 1);
    rst_n = 0;
    #1 chk("rst_drop_tvalid", c2h_tvalid, 0);
    chk("rst_h2c_tready", h2c_tready, 1);
    beat_q.delete();
    @(negedge clk);
    rst_n = 1;
    axil_rd("beats_after_rst", 8'h1C, 0);
    axil_rd("src_after_rst", 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
